// File: rtl/ctrl_pkg.sv
// Shared control definitions: opcodes, ALU codes, data types and the
// control bundle carried down the D->E->M->W pipeline.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ctrl_t;

    localparam logic [1:0] DT_WORD = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_BYTE = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       result_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        alu_ctrl_t  alu_ctrl;
        logic [1:0] data_type;
        logic [2:0] funct3;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic logic [1:0] data_type_of(input logic [1:0] f);
        case (f)
            2'b01:   return DT_HALF;
            2'b00:   return DT_BYTE;
            default: return DT_WORD;
        endcase
    endfunction

    function automatic alu_ctrl_t alu_of(
        input logic [2:0] f3,
        input logic       f75,
        input logic       op5
    );
        case (f3)
            3'b000:  return (f75 && op5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f75 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational decode of opcode/funct fields into a control bundle;
// unknown opcodes raise illegal and decode to a bubble.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct75,
    output ctrl_t      ctrl,
    output logic [1:0] imm_src,
    output logic       illegal
);

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        imm_src = IMM_I;
        illegal = 1'b0;
        unique case (1'b1)
            (op == OP_R): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = alu_of(funct3, funct75, op[5]);
            end
            (op == OP_I): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_of(funct3, funct75, op[5]);
            end
            (op == OP_LOAD): begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.data_type  = data_type_of(funct3[1:0]);
            end
            (op == OP_STORE): begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.data_type = data_type_of(funct3[1:0]);
                imm_src        = IMM_S;
            end
            (op == OP_BRANCH): begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
                ctrl.funct3   = funct3;
                imm_src       = IMM_B;
            end
            (op == OP_JAL): begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                imm_src        = IMM_J;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_control.sv
// Pipelined control unit: decode, D->E->M->W control registers, hazards.
// Define FULL_BRANCH_EN for full BEQ/BNE/BLT/BGE/BLTU/BGEU conditions.
module pipelined_control
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op_d,
    input  logic [2:0]            funct3_d,
    input  logic                  funct75_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  zero_e,
    input  logic                  lt_e,
    input  logic                  ltu_e,
    output logic [1:0]            imm_src_d,
    output logic                  illegal_d,
    output logic [ALU_CTRL_W-1:0] alu_control_e,
    output logic                  alu_src_e,
    output logic                  pc_src_e,
    output logic                  mem_write_m,
    output logic [1:0]            data_type_m,
    output logic                  result_src_w,
    output logic                  reg_write_w,
    output logic [REG_ADDR_W-1:0] rd_w,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e
);

    ctrl_t                 ctrl_d;
    ctrl_t                 e_q;
    logic [REG_ADDR_W-1:0] rd_e;
    logic                  reg_write_m;
    logic                  result_src_m;
    logic [REG_ADDR_W-1:0] rd_m;
    logic                  cond;
    logic                  load_use;

    ctrl_decoder u_dec (
        .op      (op_d),
        .funct3  (funct3_d),
        .funct75 (funct75_d),
        .ctrl    (ctrl_d),
        .imm_src (imm_src_d),
        .illegal (illegal_d)
    );

`ifdef FULL_BRANCH_EN
    always_comb begin
        cond = 1'b0;
        case (e_q.funct3)
            3'b000:  cond = zero_e;
            3'b001:  cond = ~zero_e;
            3'b100:  cond = lt_e;
            3'b101:  cond = ~lt_e;
            3'b110:  cond = ltu_e;
            3'b111:  cond = ~ltu_e;
            default: cond = 1'b0;
        endcase
    end
`else
    logic unused_flags;
    assign unused_flags = lt_e ^ ltu_e ^ (^e_q.funct3);
    assign cond         = zero_e;
`endif

    assign pc_src_e = e_q.jump | (e_q.branch & cond);

    assign load_use = e_q.result_src & e_q.reg_write
                    & (rd_e != '0)
                    & ((rd_e == rs1_d) | (rd_e == rs2_d));

    // A redirect discards the decode slot, so it overrides any stall
    assign stall_d = load_use & ~pc_src_e;
    assign flush_d = pc_src_e;
    assign flush_e = load_use | pc_src_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q  <= CTRL_BUBBLE;
            rd_e <= '0;
        end else if (flush_e || illegal_d) begin
            e_q  <= CTRL_BUBBLE;
            rd_e <= '0;
        end else begin
            e_q  <= ctrl_d;
            rd_e <= rd_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_m  <= 1'b0;
            result_src_m <= 1'b0;
            mem_write_m  <= 1'b0;
            data_type_m  <= 2'b00;
            rd_m         <= '0;
        end else begin
            reg_write_m  <= e_q.reg_write;
            result_src_m <= e_q.result_src;
            mem_write_m  <= e_q.mem_write;
            data_type_m  <= e_q.data_type;
            rd_m         <= rd_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_w  <= 1'b0;
            result_src_w <= 1'b0;
            rd_w         <= '0;
        end else begin
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
            rd_w         <= rd_m;
        end
    end

    assign alu_control_e = ALU_CTRL_W'(e_q.alu_ctrl);
    assign alu_src_e     = e_q.alu_src;

endmodule

// File: tb/tb_pipelined_control.sv
// Scoreboard bench for pipelined_control: stimulus queues timed
// expectations, a negedge monitor pops and compares them.
module tb_pipelined_control;

    localparam bit FULL =
`ifdef FULL_BRANCH_EN
        1'b1;
`else
        1'b0;
`endif

    localparam logic [6:0] R = 7'b0110011;
    localparam logic [6:0] I = 7'b0010011;
    localparam logic [6:0] L = 7'b0000011;
    localparam logic [6:0] S = 7'b0100011;
    localparam logic [6:0] B = 7'b1100011;
    localparam logic [6:0] J = 7'b1101111;

    localparam int ILL = 0, IMM = 1, ALU = 2, ASRC = 3, PC = 4;
    localparam int MW = 5, DT = 6, RSRC = 7, RW = 8, RD = 9;
    localparam int STALL = 10, FD = 11, FE = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op_d;
    logic [2:0] funct3_d;
    logic       funct75_d;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       zero_e, lt_e, ltu_e;
    logic [1:0] imm_src_d;
    logic       illegal_d;
    logic [3:0] alu_control_e;
    logic       alu_src_e, pc_src_e, mem_write_m;
    logic [1:0] data_type_m;
    logic       result_src_w, reg_write_w;
    logic [4:0] rd_w;
    logic       stall_d, flush_d, flush_e;

    pipelined_control #(.ALU_CTRL_W(4), .REG_ADDR_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_d          (op_d),
        .funct3_d      (funct3_d),
        .funct75_d     (funct75_d),
        .rs1_d         (rs1_d),
        .rs2_d         (rs2_d),
        .rd_d          (rd_d),
        .zero_e        (zero_e),
        .lt_e          (lt_e),
        .ltu_e         (ltu_e),
        .imm_src_d     (imm_src_d),
        .illegal_d     (illegal_d),
        .alu_control_e (alu_control_e),
        .alu_src_e     (alu_src_e),
        .pc_src_e      (pc_src_e),
        .mem_write_m   (mem_write_m),
        .data_type_m   (data_type_m),
        .result_src_w  (result_src_w),
        .reg_write_w   (reg_write_w),
        .rd_w          (rd_w),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .flush_e       (flush_e)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] get(input int s);
        case (s)
            ILL:     return 32'(illegal_d);
            IMM:     return 32'(imm_src_d);
            ALU:     return 32'(alu_control_e);
            ASRC:    return 32'(alu_src_e);
            PC:      return 32'(pc_src_e);
            MW:      return 32'(mem_write_m);
            DT:      return 32'(data_type_m);
            RSRC:    return 32'(result_src_w);
            RW:      return 32'(reg_write_w);
            RD:      return 32'(rd_w);
            STALL:   return 32'(stall_d);
            FD:      return 32'(flush_d);
            default: return 32'(flush_e);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                logic [31:0] act;
                act = get(q[i].sig);
                n_checks++;
                if (act !== q[i].val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                             q[i].nm, cyc, act, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic chk(input int c, input int s,
                       input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic f75, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd,
                         input logic z, input logic lt,
                         input logic ltu);
        @(posedge clk);
        #1;
        op_d      = op;
        funct3_d  = f3;
        funct75_d = f75;
        rs1_d     = r1;
        rs2_d     = r2;
        rd_d      = rd;
        zero_e    = z;
        lt_e      = lt;
        ltu_e     = ltu;
    endtask

    task automatic idle(input logic z, input logic lt, input logic ltu);
        issue(I, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, z, lt, ltu);
    endtask

    task automatic regs_zero(input int c, input string nm);
        chk(c, ALU, 0, {nm, "_alu"});
        chk(c, ASRC, 0, {nm, "_asrc"});
        chk(c, PC, 0, {nm, "_pc"});
        chk(c, MW, 0, {nm, "_mw"});
        chk(c, DT, 0, {nm, "_dt"});
        chk(c, RSRC, 0, {nm, "_rsrc"});
        chk(c, RW, 0, {nm, "_rw"});
        chk(c, RD, 0, {nm, "_rd"});
        chk(c, STALL, 0, {nm, "_stall"});
        chk(c, FD, 0, {nm, "_fd"});
        chk(c, FE, 0, {nm, "_fe"});
    endtask

    initial begin
        int c, ca, cb, cs;
        rst_n = 1'b0;
        op_d = I; funct3_d = 0; funct75_d = 0;
        rs1_d = 0; rs2_d = 0; rd_d = 0;
        zero_e = 0; lt_e = 0; ltu_e = 0;
        repeat (2) @(posedge clk);
        #1;
        regs_zero(cyc, "reset");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // add x3,x1,x2
        issue(R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 0, 0, 0);
        c = cyc;
        chk(c, ILL, 0, "add_ill");
        chk(c, IMM, 0, "add_imm");
        chk(c, STALL, 0, "add_stall");
        chk(c + 1, ALU, 0, "add_alu");
        chk(c + 1, ASRC, 0, "add_asrc");
        chk(c + 3, RW, 1, "add_rw");
        chk(c + 3, RD, 3, "add_rd");
        chk(c + 3, RSRC, 0, "add_rsrc");

        // sub x4,x3,x1
        issue(R, 3'b000, 1'b1, 5'd3, 5'd1, 5'd4, 0, 0, 0);
        c = cyc;
        chk(c + 1, ALU, 1, "sub_alu");
        chk(c + 3, RD, 4, "sub_rd");

        // addi with funct75=1: still ADD
        issue(I, 3'b000, 1'b1, 5'd1, 5'd0, 5'd2, 0, 0, 0);
        c = cyc;
        chk(c + 1, ALU, 0, "addi_alu");
        chk(c + 1, ASRC, 1, "addi_asrc");

        // sra x10
        issue(R, 3'b101, 1'b1, 5'd1, 5'd2, 5'd10, 0, 0, 0);
        c = cyc;
        chk(c + 1, ALU, 7, "sra_alu");

        // sw x5,8(x2)
        issue(S, 3'b010, 1'b0, 5'd2, 5'd5, 5'd8, 0, 0, 0);
        c = cyc;
        chk(c, IMM, 1, "sw_imm");
        chk(c + 1, ALU, 0, "sw_alu");
        chk(c + 1, ASRC, 1, "sw_asrc");
        chk(c + 2, MW, 1, "sw_mw");
        chk(c + 2, DT, 0, "sw_dt");
        chk(c + 3, RW, 0, "sw_rw");

        // lh x5 then add x6,x5,x1 (load-use)
        issue(L, 3'b001, 1'b0, 5'd1, 5'd0, 5'd5, 0, 0, 0);
        c = cyc;
        chk(c + 2, DT, 1, "lh_dt");
        chk(c + 2, MW, 0, "lh_mw");
        chk(c + 3, RW, 1, "lh_rw");
        chk(c + 3, RSRC, 1, "lh_rsrc");
        chk(c + 3, RD, 5, "lh_rd");
        issue(R, 3'b000, 1'b0, 5'd5, 5'd1, 5'd6, 0, 0, 0);
        ca = cyc;
        chk(ca, STALL, 1, "lu_stall");
        chk(ca, FE, 1, "lu_fe");
        chk(ca, FD, 0, "lu_fd");
        issue(R, 3'b000, 1'b0, 5'd5, 5'd1, 5'd6, 0, 0, 0);
        chk(cyc, STALL, 0, "lu_release");
        chk(cyc, FE, 0, "lu_fe_release");
        chk(ca + 3, RW, 0, "lu_bubble_w");
        chk(ca + 4, RW, 1, "lu_add_rw");
        chk(ca + 4, RD, 6, "lu_add_rd");

        // lw x0 then a reader of x0: no stall
        issue(L, 3'b010, 1'b0, 5'd1, 5'd0, 5'd0, 0, 0, 0);
        issue(R, 3'b000, 1'b0, 5'd0, 5'd2, 5'd7, 0, 0, 0);
        chk(cyc, STALL, 0, "rd0_stall");
        chk(cyc, FE, 0, "rd0_fe");
        idle(0, 0, 0);

        // bne, zero=0
        issue(B, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0, 0, 0, 0);
        cb = cyc;
        chk(cb, IMM, 2, "bne_imm");
        idle(0, 0, 0);
        chk(cb + 1, ALU, 1, "bne_alu");
        chk(cb + 1, PC, 32'(FULL), "bne_pc");
        chk(cb + 1, FD, 32'(FULL), "bne_fd");
        chk(cb + 1, FE, 32'(FULL), "bne_fe");
        chk(cb + 1, STALL, 0, "bne_stall");

        // blt, lt=1 zero=0
        issue(B, 3'b100, 1'b0, 5'd1, 5'd2, 5'd0, 0, 0, 0);
        cb = cyc;
        idle(0, 1, 0);
        chk(cb + 1, PC, 32'(FULL), "blt_pc");

        // beq taken; the following add gets flushed
        issue(B, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 0, 0, 0);
        cb = cyc;
        issue(R, 3'b000, 1'b0, 5'd5, 5'd0, 5'd9, 1, 0, 0);
        c = cyc;
        chk(cb + 1, PC, 1, "beq_pc");
        chk(cb + 1, FD, 1, "beq_fd");
        chk(cb + 1, FE, 1, "beq_fe");
        chk(cb + 1, STALL, 0, "beq_stall");
        chk(cb + 3, RW, 0, "beq_rw");
        chk(c + 3, RW, 0, "beq_flushed_rw");
        chk(c + 3, RD, 0, "beq_flushed_rd");

        // jal x1
        issue(J, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 0, 0, 0);
        c = cyc;
        chk(c, IMM, 3, "jal_imm");
        idle(0, 0, 0);
        chk(c + 1, PC, 1, "jal_pc");
        chk(c + 1, ALU, 0, "jal_alu");
        chk(c + 1, FD, 1, "jal_fd");
        chk(c + 3, RW, 1, "jal_rw");
        chk(c + 3, RD, 1, "jal_rd");

        // illegal opcode
        issue(7'h7f, 3'b010, 1'b0, 5'd1, 5'd2, 5'd8, 0, 0, 0);
        c = cyc;
        #1;
        n_checks++;
        if (illegal_d !== 1'b1) begin
            n_fail++;
            $display("FAIL ill_direct got=%0b", illegal_d);
        end
        chk(c, ILL, 1, "ill_flag");
        chk(c, IMM, 0, "ill_imm");
        chk(c + 1, ASRC, 0, "ill_asrc");
        chk(c + 2, MW, 0, "ill_mw");
        chk(c + 3, RW, 0, "ill_rw");
        chk(c + 3, RD, 0, "ill_rd");
        idle(0, 0, 0);
        idle(0, 0, 0);

        // fill the pipe, then reset asynchronously mid-stall
        issue(R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 0, 0, 0);
        issue(S, 3'b010, 1'b0, 5'd2, 5'd4, 5'd0, 0, 0, 0);
        issue(L, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5, 0, 0, 0);
        issue(R, 3'b000, 1'b0, 5'd5, 5'd1, 5'd6, 0, 0, 0);
        cs = cyc;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (reg_write_w !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_direct_rw got=%0b", reg_write_w);
        end
        n_checks++;
        if (rd_w !== 5'd0) begin
            n_fail++;
            $display("FAIL midrst_direct_rd got=%0h", rd_w);
        end
        n_checks++;
        if (mem_write_m !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_direct_mw got=%0b", mem_write_m);
        end
        n_checks++;
        if (alu_control_e !== 4'd0) begin
            n_fail++;
            $display("FAIL midrst_direct_alu got=%0h", alu_control_e);
        end
        n_checks++;
        if (stall_d !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_direct_stall got=%0b", stall_d);
        end
        n_checks++;
        if (flush_e !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_direct_fe got=%0b", flush_e);
        end
        regs_zero(cs, "midrst");
        @(negedge clk);
        #2 rst_n = 1'b1;

        idle(0, 0, 0);
        issue(R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd12, 0, 0, 0);
        c = cyc;
        chk(c + 3, RW, 1, "post_rst_rw");
        chk(c + 3, RD, 12, "post_rst_rd");
        repeat (5) idle(0, 0, 0);
        @(negedge clk);
        #1;

        foreach (q[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s never evaluated (cyc %0d)", q[i].nm, q[i].cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_control.md
PIPELINED_CONTROL -- requirements
Module: pipelined_control

Interface
REQ-001 SHALL have parameter ALU_CTRL_W, default 4, ALU control code width.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports op_d in 7, funct3_d in 3, funct75_d in 1  decode-stage instruction fields.
REQ-006 SHALL have ports rs1_d, rs2_d, rd_d  in  REG_ADDR_W  decode-stage register addresses.
REQ-007 SHALL have ports zero_e, lt_e, ltu_e  in  1  EX-stage ALU flags (equal, signed less, unsigned less).
REQ-008 SHALL have ports imm_src_d out 2, illegal_d out 1  combinational decode outputs.
REQ-009 SHALL have ports alu_control_e out ALU_CTRL_W, alu_src_e out 1, pc_src_e out 1  EX-stage controls.
REQ-010 SHALL have ports mem_write_m out 1, data_type_m out 2  MEM-stage controls.
REQ-011 SHALL have ports result_src_w out 1, reg_write_w out 1, rd_w out REG_ADDR_W  WB-stage controls.
REQ-012 SHALL have ports stall_d, flush_d, flush_e  out 1  hazard controls to datapath pipeline registers.

Function
REQ-013 SHALL decode op_d combinationally: R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, JAL 1101111.
REQ-014 Unknown opcode SHALL assert illegal_d and decode to a bubble.
REQ-015 Bubble SHALL be reg_write=0, mem_write=0, branch=0, jump=0, remaining fields 0.
REQ-016 ALU code SHALL follow the package encoding: add for load/store/JAL, subtract for branch, funct3/funct75 for R/I; funct75 selects SUB only when op_d[5]=1.
REQ-017 data_type SHALL be 00 word (funct3[1:0]=10), 01 half (01), 10 byte (00).
REQ-018 Decoded controls SHALL pass through D->E->M->W registers: EX outputs 1 cycle, MEM 2, WB 3 after decode.
REQ-019 pc_src_e SHALL equal jump_e OR (branch_e AND cond), cond taken from registered funct3_e.
REQ-020 Load-use hazard SHALL be: result_src_e=1 AND reg_write_e=1 AND rd_e!=0 AND (rd_e==rs1_d OR rd_e==rs2_d).
REQ-021 On load-use: stall_d=1, flush_e=1, E register loads bubble, D decode held.
REQ-022 On pc_src_e=1: flush_d=1, flush_e=1, stall_d=0, E register loads bubble.
REQ-023 Simultaneous load-use and pc_src_e SHALL resolve as flush; redirect wins.
REQ-024 rd=0 SHALL never trigger a stall.
REQ-025 M and W registers SHALL always advance; no stall beyond D.

Reset
REQ-026 rst_n low SHALL immediately load bubble into E, M, W registers, regardless of clk.
REQ-027 After reset all registered outputs SHALL be 0; stall_d, flush_d, flush_e SHALL be 0.
REQ-028 Reset asserted mid-stall or mid-flush SHALL discard in-flight state; no replay.

Configuration
REQ-029 Macro FULL_BRANCH_EN defined: cond SHALL be BEQ zero, BNE !zero, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu; funct3 010/011 never taken.
REQ-030 Macro undefined: cond SHALL be zero_e for every branch funct3; lt_e, ltu_e ignored.

Structure
REQ-031 Package ctrl_pkg SHALL hold opcode constants, ALU control enum, data_type codes, and the control-bundle struct.
REQ-032 Combinational decode SHALL be sub-module ctrl_decoder; pipeline registers and hazard logic stay in pipelined_control.

Verification
REQ-033 add x3,x1,x2 (0110011/000/0) -> alu_control_e=ADD at cycle+1, reg_write_w=1, rd_w=3 at cycle+3.
REQ-034 lw x5 then add x6,x5,x1 next cycle -> stall_d=1, flush_e=1 for one cycle, reg_write_e=0 bubble.
REQ-035 bne with zero_e=0 -> pc_src_e=1, flush_d=flush_e=1; with macro undefined -> pc_src_e=0.
REQ-036 beq taken plus concurrent load-use -> flush_d=1, stall_d=0.
REQ-037 op_d=1111111 -> illegal_d=1, no writes reach MEM/WB.
REQ-038 rst_n low mid-pipeline, no clk edge -> all registered outputs 0 immediately.
